// File: rtl/generic_sram_line_en_req_bridge.sv
// Valid/ready request stream to line-enable SRAM bridge.
//
// Each accepted request becomes a single-cycle SRAM strobe. Read data comes back one cycle after
// sram_read_en, is captured into a response FIFO, and is returned in request order on a
// valid/ready response channel. Requests are only accepted while the FIFO has a guaranteed free
// slot for every read already in flight, so back-pressure never drops read data.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write, req_addr, req_wdata  request payload (1 = write)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata                    read response data
//   sram_addr, sram_write_data   SRAM address / write data (follow the request inputs)
//   sram_write_en, sram_read_en  SRAM strobes, high only in the accept cycle
//   sram_read_data               SRAM read data, valid the cycle after sram_read_en
module generic_sram_line_en_req_bridge #(
  parameter int unsigned NUM_ADDR_BITS = 32,
  parameter int unsigned NUM_DATA_BITS = 32,
  parameter int unsigned RSP_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [NUM_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_DATA_BITS-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_DATA_BITS-1:0] rsp_rdata,
  output logic [NUM_ADDR_BITS-1:0] sram_addr,
  output logic [NUM_DATA_BITS-1:0] sram_write_data,
  output logic                     sram_write_en,
  output logic                     sram_read_en,
  input  logic [NUM_DATA_BITS-1:0] sram_read_data
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(RSP_DEPTH);

  logic [CntW-1:0]          count_q, count_d;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic                     rd_pend_q;
  logic                     rst_done_q;
  logic [NUM_DATA_BITS-1:0] mem_q [RSP_DEPTH];

  logic            acc;
  logic            push;
  logic            pop;
  logic [CntW-1:0] used;

  // Slots already claimed: queued responses plus the read whose data lands this edge.
  // Depends only on registered state, so req_ready has no path from any input.
  assign used      = count_q + CntW'(rd_pend_q);
  assign req_ready = rst_done_q && (used < DepthC);
  assign acc       = req_valid && req_ready;

  assign sram_addr       = req_addr;
  assign sram_write_data = req_wdata;
  assign sram_write_en   = acc && req_write;
  assign sram_read_en    = acc && !req_write;

  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = mem_q[rd_ptr_q];

  // The credit check guarantees a push never meets a full FIFO.
  assign push = rd_pend_q;
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      rd_pend_q  <= acc && !req_write;
      count_q    <= count_d;
      // Depth is a power of two, so natural overflow wraps the pointers.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage is not reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_read_data;
    end
  end

endmodule
